// File: rtl/mem_axil_bridge.sv
// mem_axil_bridge: responder for the MEM-stage request/done handshake.
// Each accepted load or store runs as exactly one AXI4-Lite master
// transaction, and completion is reported with a single-cycle done pulse.
module mem_axil_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  // MEM-stage request/done handshake
  input  logic                    mem_req_i,
  input  logic                    mem_we_i,
  input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] mem_strb_i,
  output logic                    mem_done_o,
  output logic [DATA_WIDTH-1:0]   mem_rdata_o,
  output logic                    mem_err_o,
  // AXI4-Lite write address channel
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr_o,
  output logic [2:0]              m_axil_awprot_o,
  output logic                    m_axil_awvalid_o,
  input  logic                    m_axil_awready_i,
  // AXI4-Lite write data channel
  output logic [DATA_WIDTH-1:0]   m_axil_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb_o,
  output logic                    m_axil_wvalid_o,
  input  logic                    m_axil_wready_i,
  // AXI4-Lite write response channel
  input  logic [1:0]              m_axil_bresp_i,
  input  logic                    m_axil_bvalid_i,
  output logic                    m_axil_bready_o,
  // AXI4-Lite read address channel
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr_o,
  output logic [2:0]              m_axil_arprot_o,
  output logic                    m_axil_arvalid_o,
  input  logic                    m_axil_arready_i,
  // AXI4-Lite read data channel
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata_i,
  input  logic [1:0]              m_axil_rresp_i,
  input  logic                    m_axil_rvalid_i,
  output logic                    m_axil_rready_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   strb_q, strb_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    aw_fire;
  logic                    w_fire;

  assign aw_fire = awvalid_q & m_axil_awready_i;
  assign w_fire  = wvalid_q & m_axil_wready_i;

  // State and datapath registers, all cleared by synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: sequence one AXI transaction per accepted request
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (mem_req_i) begin
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          strb_d  = mem_strb_i;
          err_d   = 1'b0;
          if (mem_we_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W retire independently; a channel already done counts as complete
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire)  wvalid_d  = 1'b0;
        if ((!awvalid_q || aw_fire) && (!wvalid_q || w_fire)) begin
          state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m_axil_bvalid_i) begin
          err_d   = (m_axil_bresp_i != 2'b00);
          state_d = S_DONE;
        end
      end
      S_RD_REQ: begin
        if (m_axil_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (m_axil_rvalid_i) begin
          rdata_d = m_axil_rdata_i;
          err_d   = (m_axil_rresp_i != 2'b00);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // mem_req_i is deliberately ignored here: it still belongs to the retiring access
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign m_axil_awaddr_o  = addr_q;
  assign m_axil_awprot_o  = 3'b000;
  assign m_axil_awvalid_o = awvalid_q;
  assign m_axil_wdata_o   = wdata_q;
  assign m_axil_wstrb_o   = strb_q;
  assign m_axil_wvalid_o  = wvalid_q;
  assign m_axil_bready_o  = (state_q == S_WR_RESP);
  assign m_axil_araddr_o  = addr_q;
  assign m_axil_arprot_o  = 3'b000;
  assign m_axil_arvalid_o = arvalid_q;
  assign m_axil_rready_o  = (state_q == S_RD_RESP);

  assign mem_done_o  = (state_q == S_DONE);
  assign mem_err_o   = (state_q == S_DONE) && err_q;
  assign mem_rdata_o = rdata_q;

endmodule
